temporal_ngram_encoder: RTL and testbench



---
 rtl/temporal_ngram_encoder_pkg.sv | 28 ++
 rtl/temporal_ngram_encoder_if.sv | 43 ++++
 rtl/temporal_ngram_encoder_history.sv | 66 ++++++
 rtl/temporal_ngram_encoder.sv | 151 +++++++++++++++
 tb/tb_temporal_ngram_encoder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/temporal_ngram_encoder_pkg.sv
// Shared definitions for the temporal n-gram encoder: default sizes,
// FSM state encoding and the ceilLog2 width helper.
// The hypervector width can be fixed at build time with +define+HV_DIMENSION=<n>.
`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif

package temporal_ngram_encoder_pkg;

  localparam int HV_DIMENSION_DEFAULT = `HV_DIMENSION;
  localparam int NGRAM_SIZE_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    OUTPUT_STABLE = 2'd1
  } state_t;

  // Smallest r with 2**r >= value.
  function automatic int ceilLog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/temporal_ngram_encoder_if.sv
// Sample-in / n-gram-out handshake bundle of the temporal n-gram encoder.
// master: upstream + downstream side, slave: the encoder.
// Optional macro NGRAM_FLUSH_EN adds the Flush_SI request line.
interface temporal_ngram_encoder_if
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT
);
  logic                      ValidIn_SI;
  logic                      ReadyOut_SO;
  logic [0:HV_DIMENSION-1]   HypervectorIn_mod1_DI;
  logic [0:HV_DIMENSION-1]   HypervectorIn_mod2_DI;
  logic [0:HV_DIMENSION-1]   HypervectorIn_mod3_DI;
  logic                      ReadyIn_SI;
  logic                      ValidOut_SO;
  logic [0:HV_DIMENSION-1]   NGramOut_mod1_DO;
  logic [0:HV_DIMENSION-1]   NGramOut_mod2_DO;
  logic [0:HV_DIMENSION-1]   NGramOut_mod3_DO;
`ifdef NGRAM_FLUSH_EN
  logic                      Flush_SI;
`endif

  modport master (
    output ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI,
           HypervectorIn_mod3_DI, ReadyIn_SI,
`ifdef NGRAM_FLUSH_EN
    output Flush_SI,
`endif
    input  ReadyOut_SO, ValidOut_SO, NGramOut_mod1_DO, NGramOut_mod2_DO,
           NGramOut_mod3_DO
  );

  modport slave (
    input  ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI,
           HypervectorIn_mod3_DI, ReadyIn_SI,
`ifdef NGRAM_FLUSH_EN
    input  Flush_SI,
`endif
    output ReadyOut_SO, ValidOut_SO, NGramOut_mod1_DO, NGramOut_mod2_DO,
           NGramOut_mod3_DO
  );

endinterface

// File: rtl/temporal_ngram_encoder_history.sv
// Per-modality sample history plus rotate/XOR n-gram combiner.
// NGram_D is combinational and already reflects the history as it will be
// after a shift, so the top level can register it on the accepting edge.
module ngram_history_modality
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT,
  parameter int NGRAM_SIZE   = NGRAM_SIZE_DEFAULT
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ShiftEn_S,
  input  logic                    Clear_S,
  input  logic [0:HV_DIMENSION-1] Hv_D,
  output logic [0:HV_DIMENSION-1] NGram_D
);

  typedef logic [0:HV_DIMENSION-1] hv_t;

  hv_t hist_r     [NGRAM_SIZE];
  hv_t histNext_s [NGRAM_SIZE];

  // Rotate right by k: result bit i takes source bit (i-k) mod HV_DIMENSION.
  // Bit 0 is the MSB, so moving bits to higher indices is a logical >>.
  function automatic hv_t rotr(input hv_t x, input int k);
    int kk;
    kk = k % HV_DIMENSION;
    if (kk == 0) begin
      return x;
    end else begin
      return (x >> kk) | (x << (HV_DIMENSION - kk));
    end
  endfunction

  // Post-shift history: newest sample enters at slot 0.
  always_comb begin
    histNext_s[0] = Hv_D;
    for (int k = 1; k < NGRAM_SIZE; k++) begin
      histNext_s[k] = hist_r[k-1];
    end
  end

  // History register: cleared by reset or flush, shifted on acceptance.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || Clear_S) begin
      for (int k = 0; k < NGRAM_SIZE; k++) begin
        hist_r[k] <= '0;
      end
    end else if (ShiftEn_S) begin
      hist_r <= histNext_s;
    end else begin
      hist_r <= hist_r;
    end
  end

  // Bind the window: XOR of the k-th newest sample rotated by k.
  always_comb begin
    hv_t acc;
    acc = '0;
    for (int k = 0; k < NGRAM_SIZE; k++) begin
      acc = acc ^ rotr(histNext_s[k], k);
    end
    NGram_D = acc;
  end

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Temporal n-gram encoder: binds the last NGRAM_SIZE spatial hypervectors of
// each of three modalities and hands the n-grams to the associative memory.
// Holds the IDLE/OUTPUT_STABLE handshake FSM, the warm-up counter and the
// output registers. Optional macro NGRAM_FLUSH_EN adds a history flush.
module temporal_ngram_encoder
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT,
  parameter int NGRAM_SIZE   = NGRAM_SIZE_DEFAULT
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  temporal_ngram_encoder_if.slave Bus
);

  localparam int FILL_CNTR_WIDTH = ceilLog2(NGRAM_SIZE + 1);
  localparam logic [FILL_CNTR_WIDTH-1:0] FILL_MAX = FILL_CNTR_WIDTH'(NGRAM_SIZE);

  state_t                    state_r, nextState_s;
  logic [FILL_CNTR_WIDTH-1:0] fillCntr_r;
  logic [FILL_CNTR_WIDTH:0]   fillNext_s;
  logic                      windowFull_s;
  logic                      accept_s, emit_s, handshake_s;
  logic                      readyOut_s, validOut_s;
  logic                      flushReq_s, clearHist_s;
  logic [0:HV_DIMENSION-1]   ngram1_s, ngram2_s, ngram3_s;
  logic [0:HV_DIMENSION-1]   out1_r, out2_r, out3_r;

  assign fillNext_s   = {1'b0, fillCntr_r} + {{FILL_CNTR_WIDTH{1'b0}}, 1'b1};
  assign windowFull_s = (fillNext_s >= {1'b0, FILL_MAX});

`ifdef NGRAM_FLUSH_EN
  logic flushPending_r;

  assign flushReq_s  = Bus.Flush_SI;
  // A flush seen while an output is pending takes effect on its handshake edge.
  assign clearHist_s = ((state_r == IDLE) && flushReq_s) ||
                       (handshake_s && (flushReq_s || flushPending_r));

  // Remember a flush requested during OUTPUT_STABLE until the handshake.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      flushPending_r <= 1'b0;
    end else if (handshake_s) begin
      flushPending_r <= 1'b0;
    end else if ((state_r == OUTPUT_STABLE) && flushReq_s) begin
      flushPending_r <= 1'b1;
    end else begin
      flushPending_r <= flushPending_r;
    end
  end
`else
  assign flushReq_s  = 1'b0;
  assign clearHist_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and handshake decode; a flush in IDLE blocks acceptance.
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    emit_s      = 1'b0;
    handshake_s = 1'b0;
    readyOut_s  = 1'b0;
    validOut_s  = 1'b0;
    case (state_r)
      IDLE: begin
        readyOut_s = ~flushReq_s;
        if (Bus.ValidIn_SI && !flushReq_s) begin
          accept_s = 1'b1;
          if (windowFull_s) begin
            emit_s      = 1'b1;
            nextState_s = OUTPUT_STABLE;
          end else begin
            nextState_s = IDLE;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      OUTPUT_STABLE: begin
        validOut_s = 1'b1;
        if (Bus.ReadyIn_SI) begin
          handshake_s = 1'b1;
          nextState_s = IDLE;
        end else begin
          nextState_s = OUTPUT_STABLE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Warm-up counter: saturates at NGRAM_SIZE, cleared by reset or flush.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || clearHist_s) begin
      fillCntr_r <= '0;
    end else if (accept_s && (fillCntr_r != FILL_MAX)) begin
      fillCntr_r <= fillNext_s[FILL_CNTR_WIDTH-1:0];
    end else begin
      fillCntr_r <= fillCntr_r;
    end
  end

  ngram_history_modality #(.HV_DIMENSION(HV_DIMENSION), .NGRAM_SIZE(NGRAM_SIZE)) uHist1 (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ShiftEn_S(accept_s), .Clear_S(clearHist_s),
    .Hv_D(Bus.HypervectorIn_mod1_DI), .NGram_D(ngram1_s)
  );
  ngram_history_modality #(.HV_DIMENSION(HV_DIMENSION), .NGRAM_SIZE(NGRAM_SIZE)) uHist2 (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ShiftEn_S(accept_s), .Clear_S(clearHist_s),
    .Hv_D(Bus.HypervectorIn_mod2_DI), .NGram_D(ngram2_s)
  );
  ngram_history_modality #(.HV_DIMENSION(HV_DIMENSION), .NGRAM_SIZE(NGRAM_SIZE)) uHist3 (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ShiftEn_S(accept_s), .Clear_S(clearHist_s),
    .Hv_D(Bus.HypervectorIn_mod3_DI), .NGram_D(ngram3_s)
  );

  // Output registers: loaded on the accepting edge that completes a window.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      out1_r <= '0;
      out2_r <= '0;
      out3_r <= '0;
    end else if (emit_s) begin
      out1_r <= ngram1_s;
      out2_r <= ngram2_s;
      out3_r <= ngram3_s;
    end else begin
      out1_r <= out1_r;
      out2_r <= out2_r;
      out3_r <= out3_r;
    end
  end

  assign Bus.ReadyOut_SO      = readyOut_s;
  assign Bus.ValidOut_SO      = validOut_s;
  assign Bus.NGramOut_mod1_DO = out1_r;
  assign Bus.NGramOut_mod2_DO = out2_r;
  assign Bus.NGramOut_mod3_DO = out3_r;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Bench for temporal_ngram_encoder (HV_DIMENSION=8, NGRAM_SIZE=3).
// Table-driven sample sequences; expected n-grams go to a queue when a
// window-completing sample is accepted and are compared on each handshake.
module tb_temporal_ngram_encoder;

  typedef logic [0:7] hv_t;

  typedef struct {
    hv_t  in1, in2, in3;
    logic expValid;
    hv_t  exp1, exp2, exp3;
  } vec_t;

  typedef struct {
    hv_t m1, m2, m3;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t expMon;
  vec_t warmTbl[5];
  vec_t modTbl[3];
`ifdef NGRAM_FLUSH_EN
  vec_t flushTbl[3];
`endif

  always #5 clk = ~clk;

  temporal_ngram_encoder_if #(.HV_DIMENSION(8)) bus ();

  temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3)) dut (
    .Clk_CI  (clk),
    .Reset_RI(rst),
    .Bus     (bus)
  );

  task automatic checkHv(input string name, input hv_t act, input hv_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Scoreboard: every completed transfer is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.ValidOut_SO === 1'b1 && bus.ReadyIn_SI === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %b with nothing expected", bus.NGramOut_mod1_DO);
      end else begin
        expMon = expQ.pop_front();
        checkHv("ngram_mod1", bus.NGramOut_mod1_DO, expMon.m1);
        checkHv("ngram_mod2", bus.NGramOut_mod2_DO, expMon.m2);
        checkHv("ngram_mod3", bus.NGramOut_mod3_DO, expMon.m3);
      end
    end
  end

  // Offer one sample when the encoder is ready; then check whether it emitted.
  task automatic sendVec(input vec_t v);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.ReadyOut_SO === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ReadyOut_SO %b required 1", bus.ReadyOut_SO);
      return;
    end
    bus.HypervectorIn_mod1_DI = v.in1;
    bus.HypervectorIn_mod2_DI = v.in2;
    bus.HypervectorIn_mod3_DI = v.in3;
    bus.ValidIn_SI = 1'b1;
    @(posedge clk);
    #1;
    bus.ValidIn_SI = 1'b0;
    if (v.expValid) expQ.push_back('{v.exp1, v.exp2, v.exp3});
    @(negedge clk);
    checkBit("valid_after_accept", bus.ValidOut_SO, v.expValid);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic sendAll(input hv_t m, input logic ev, input hv_t e);
    vec_t v;
    v = '{m, m, m, ev, e, e, e};
    sendVec(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Same data on every modality: warm-up, then sliding window.
    warmTbl[0] = '{8'b10000000, 8'b10000000, 8'b10000000, 1'b0, 8'b0, 8'b0, 8'b0};
    warmTbl[1] = '{8'b10000000, 8'b10000000, 8'b10000000, 1'b0, 8'b0, 8'b0, 8'b0};
    warmTbl[2] = '{8'b10000000, 8'b10000000, 8'b10000000, 1'b1, 8'b11100000, 8'b11100000, 8'b11100000};
    warmTbl[3] = '{8'b01000000, 8'b01000000, 8'b01000000, 1'b1, 8'b00100000, 8'b00100000, 8'b00100000};
    warmTbl[4] = '{8'b00000001, 8'b00000001, 8'b00000001, 1'b1, 8'b00000001, 8'b00000001, 8'b00000001};
    // Independent modalities after a mid-operation reset.
    modTbl[0] = '{8'b10000000, 8'b00000001, 8'b11111111, 1'b0, 8'b0, 8'b0, 8'b0};
    modTbl[1] = '{8'b10000000, 8'b00000001, 8'b11111111, 1'b0, 8'b0, 8'b0, 8'b0};
    modTbl[2] = '{8'b10000000, 8'b00000001, 8'b11111111, 1'b1, 8'b11100000, 8'b11000001, 8'b11111111};

    rst = 1'b1;
    bus.ValidIn_SI = 1'b0;
    bus.ReadyIn_SI = 1'b1;
    bus.HypervectorIn_mod1_DI = '0;
    bus.HypervectorIn_mod2_DI = '0;
    bus.HypervectorIn_mod3_DI = '0;
`ifdef NGRAM_FLUSH_EN
    bus.Flush_SI = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkBit("reset_valid", bus.ValidOut_SO, 1'b0);
    checkBit("reset_ready", bus.ReadyOut_SO, 1'b1);
    checkHv("reset_out1", bus.NGramOut_mod1_DO, 8'b0);
    checkHv("reset_out3", bus.NGramOut_mod3_DO, 8'b0);

    for (int i = 0; i < 5; i++) sendVec(warmTbl[i]);

    // Backpressure: output held, new sample offered but not absorbed.
    @(posedge clk);
    #1;
    bus.ReadyIn_SI = 1'b0;
    sendAll(8'b11110000, 1'b1, 8'b01100000);
    @(posedge clk);
    #1;
    bus.ValidIn_SI = 1'b1;
    bus.HypervectorIn_mod1_DI = 8'b11111111;
    bus.HypervectorIn_mod2_DI = 8'b11111111;
    bus.HypervectorIn_mod3_DI = 8'b11111111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkBit("bp_ready_low", bus.ReadyOut_SO, 1'b0);
      checkBit("bp_valid_high", bus.ValidOut_SO, 1'b1);
      checkHv("bp_out1_hold", bus.NGramOut_mod1_DO, 8'b01100000);
    end
    @(posedge clk);
    #1;
    bus.ValidIn_SI = 1'b0;
    bus.ReadyIn_SI = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkBit("release_valid", bus.ValidOut_SO, 1'b0);
    checkBit("release_ready", bus.ReadyOut_SO, 1'b1);
    // Window [0, 11110000, 00000001]: proves 11111111 was never absorbed.
    sendAll(8'b00000000, 1'b1, 8'b00111000);

    // Reset while an output is pending.
    @(posedge clk);
    #1;
    bus.ReadyIn_SI = 1'b0;
    sendAll(8'b10000000, 1'b1, 8'b10111100);
    checkHv("pending_out1", bus.NGramOut_mod1_DO, 8'b10111100);
    applyReset();
    @(negedge clk);
    checkBit("midrst_valid", bus.ValidOut_SO, 1'b0);
    checkBit("midrst_ready", bus.ReadyOut_SO, 1'b1);
    checkHv("midrst_out1", bus.NGramOut_mod1_DO, 8'b0);
    checkHv("midrst_out2", bus.NGramOut_mod2_DO, 8'b0);
    @(posedge clk);
    #1;
    bus.ReadyIn_SI = 1'b1;
    for (int i = 0; i < 3; i++) sendVec(modTbl[i]);

`ifdef NGRAM_FLUSH_EN
    // Flush in IDLE after two samples; flush also beats a same-cycle sample.
    flushTbl[0] = '{8'b01000000, 8'b01000000, 8'b01000000, 1'b0, 8'b0, 8'b0, 8'b0};
    flushTbl[1] = '{8'b01000000, 8'b01000000, 8'b01000000, 1'b0, 8'b0, 8'b0, 8'b0};
    flushTbl[2] = '{8'b01000000, 8'b01000000, 8'b01000000, 1'b1, 8'b01110000, 8'b01110000, 8'b01110000};
    applyReset();
    sendAll(8'b10000000, 1'b0, 8'b0);
    sendAll(8'b10000000, 1'b0, 8'b0);
    @(posedge clk);
    #1;
    bus.Flush_SI = 1'b1;
    bus.ValidIn_SI = 1'b1;
    bus.HypervectorIn_mod1_DI = 8'b11111111;
    bus.HypervectorIn_mod2_DI = 8'b11111111;
    bus.HypervectorIn_mod3_DI = 8'b11111111;
    @(negedge clk);
    checkBit("flush_ready_low", bus.ReadyOut_SO, 1'b0);
    @(posedge clk);
    #1;
    bus.Flush_SI = 1'b0;
    bus.ValidIn_SI = 1'b0;
    for (int i = 0; i < 3; i++) sendVec(flushTbl[i]);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drained_queue: %0d left required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
